shift_register_universal: RTL and testbench
===========================================

SHIFT_REGISTER_UNIVERSAL -- requirements
Module: shift_register_universal

Interface
REQ-001 Parameter WIDTH, default 5, register width in bits; legal range 2..32.
REQ-002 Derived CW = clog2(WIDTH)+1, width of the step count (WIDTH=5 -> CW=4).
REQ-003 The block SHALL have port clockpulse, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port enablePreset, input, 1 bit: parallel load request.
REQ-006 The block SHALL have port preset, input, WIDTH bits: parallel load value.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 hold, 01 rotate right, 10 rotate left, 11 shift right with serialIn.
REQ-008 The block SHALL have port serialIn, input, 1 bit: MSB fill bit for mode 11.
REQ-009 The block SHALL have port enableShift, input, 1 bit: single step in IDLE.
REQ-010 The block SHALL have port start, input, 1 bit: begin a counted burst.
REQ-011 The block SHALL have port count, input, CW bits: number of steps in the burst.
REQ-012 The block SHALL have port out, output, WIDTH bits: register contents.
REQ-013 The block SHALL have port notout, output, WIDTH bits: bitwise complement of out.
REQ-014 The block SHALL have port serialOut, output, 1 bit: equal to out[0].
REQ-015 The block SHALL have port busy, output, 1 bit: high while a burst is running.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle burst completion pulse.

Function
REQ-017 Step semantics SHALL be as follows. Rotate right: out <= {out[0], out[WIDTH-1:1]}. Rotate left: out <= {out[WIDTH-2:0], out[WIDTH-1]}. Mode 11: out <= {serialIn, out[WIDTH-1:1]}. Mode 00: out unchanged.
REQ-018 FSM states SHALL be IDLE, RUN and DONE; outputs SHALL be registered or decoded from state only.
REQ-019 In IDLE, priority per edge SHALL be: enablePreset (out <= preset) > start > enableShift (one step per current mode) > hold.
REQ-020 In IDLE with start=1 and enablePreset=0: latch mode into latchedMode and count into remaining, with no step on this edge; the next state SHALL be RUN if count != 0, else DONE.
REQ-021 In RUN, each edge SHALL perform one step per latchedMode and decrement remaining; the edge where remaining==1 SHALL perform the last step and move the FSM to DONE.
REQ-022 Changes to mode and count during RUN SHALL be ignored.
REQ-023 DONE SHALL last exactly one cycle, with out held, then return to IDLE.
REQ-024 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-025 A burst of c>0 steps SHALL keep busy high for c cycles, with done high in the following cycle.
REQ-026 start, enableShift and enablePreset SHALL be ignored during DONE.
REQ-027 start and enableShift SHALL be ignored during RUN.
REQ-028 enablePreset=1 during RUN SHALL abort the burst: out <= preset, next state IDLE, no done pulse.
REQ-029 latchedMode=00 SHALL run a full count-length burst with out unchanged (timed delay).
REQ-030 count > WIDTH SHALL be legal; rotation wraps naturally (rotate by WIDTH returns the original value).
REQ-031 notout and serialOut SHALL track out combinationally at all times, including during reset.

Reset
REQ-032 clear=0 SHALL immediately, without a clock, force out=0, notout=all ones, serialOut=0, busy=0, done=0, state=IDLE, remaining=0 and latchedMode=00.
REQ-033 clear asserted mid-burst SHALL abandon the burst with no done pulse.
REQ-034 After clear rises, the first active edge SHALL be processed normally.

Verification (WIDTH=5)
REQ-035 Reset then release: out=00000, notout=11111, busy=0, done=0; pulse clear low mid-cycle during a burst -> out=00000 and busy=0 with no clock edge.
REQ-036 Preset 00011, then mode=01 with enableShift held for 5 edges -> out 10001, 11000, 01100, 00110, 00011.
REQ-037 Preset 00011, start with mode=10 and count=2 -> busy high for 2 cycles, out=01100, done high 1 cycle, then IDLE.
REQ-038 Preset 00011, start with mode=11, serialIn=1, count=3 -> out=11100, serialOut=0; the same with count=0 -> done the next cycle, out=00011, busy never high.
REQ-039 Preset 00011, start with mode=01 and count=7, enablePreset=1 on the 3rd RUN cycle with preset=10101 -> out=10101, busy=0 on the next cycle, done never asserted.
REQ-040 Mode change, start and enableShift toggled during RUN -> no effect on result or timing; rotate-right burst with count=5 returns 00011 after exactly 5 busy cycles.

Source files
------------

// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load, single step or counted burst of rotate/shift steps.
// Latency: one step per clockpulse edge; a burst of c steps holds busy for c cycles, then done for one.
// No backpressure: start/enableShift are ignored while busy or done; enablePreset aborts a burst.
module shift_register_universal #(
   parameter int WIDTH = 5,
   localparam int CW = $clog2(WIDTH) + 1
) (
   input  logic             clockpulse,
   input  logic             clear,
   input  logic             enablePreset,
   input  logic [WIDTH-1:0] preset,
   input  logic [1:0]       mode,
   input  logic             serialIn,
   input  logic             enableShift,
   input  logic             start,
   input  logic [CW-1:0]    count,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] notout,
   output logic             serialOut,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    remaining;
   logic [1:0]       latched_mode;

   // One step of the register for a given mode; mode 00 leaves the value unchanged.
   function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       m,
                                                input logic             si);
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         2'b01:   r = {v[0], v[WIDTH-1:1]};
         2'b10:   r = {v[WIDTH-2:0], v[WIDTH-1]};
         2'b11:   r = {si, v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Control FSM and data register; burst mode and length are captured at start.
   always_ff @(posedge clockpulse or negedge clear) begin
      if (!clear) begin
         state        <= IDLE;
         shift_q      <= '0;
         remaining    <= '0;
         latched_mode <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (enablePreset) begin
                  shift_q <= preset;
               end else if (start) begin
                  latched_mode <= mode;
                  remaining    <= count;
                  state        <= (count != '0) ? RUN : DONE;
               end else if (enableShift) begin
                  shift_q <= step_fn(shift_q, mode, serialIn);
               end
            end
            RUN: begin
               if (enablePreset) begin
                  // Abort: load wins, burst is dropped without a done pulse.
                  shift_q   <= preset;
                  remaining <= '0;
                  state     <= IDLE;
               end else begin
                  shift_q   <= step_fn(shift_q, latched_mode, serialIn);
                  remaining <= remaining - CW'(1);
                  if (remaining == CW'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs follow the register and state directly, so they are valid during reset too.
   always_comb begin
      out       = shift_q;
      notout    = ~shift_q;
      serialOut = shift_q[0];
      busy      = (state == RUN);
      done      = (state == DONE);
   end

endmodule

// File: tb/tb_shift_register_universal.sv
module tb_shift_register_universal;

   logic       clk;
   logic       clear;
   logic       enablePreset;
   logic [4:0] preset;
   logic [1:0] mode;
   logic       serialIn;
   logic       enableShift;
   logic       start;
   logic [3:0] count;
   logic [4:0] out;
   logic [4:0] notout;
   logic       serialOut;
   logic       busy;
   logic       done;

   int tests;
   int fails;

   shift_register_universal #(.WIDTH(5)) dut (
      .clockpulse   (clk),
      .clear        (clear),
      .enablePreset (enablePreset),
      .preset       (preset),
      .mode         (mode),
      .serialIn     (serialIn),
      .enableShift  (enableShift),
      .start        (start),
      .count        (count),
      .out          (out),
      .notout       (notout),
      .serialOut    (serialOut),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] pre;
      logic [1:0] md;
      logic       si;
      logic [4:0] exp;
   } step_vec_t;

   typedef struct {
      logic [4:0] pre;
      logic [1:0] md;
      logic       si;
      logic [3:0] cnt;
      logic       disturb;
      logic [4:0] exp;
   } burst_vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] v);
      preset       = v;
      enablePreset = 1'b1;
      tick();
      enablePreset = 1'b0;
   endtask

   step_vec_t  sv[7];
   burst_vec_t bv[7];

   initial begin
      int         nbusy;
      int         guard;
      logic [4:0] e;

      tests = 0;
      fails = 0;

      sv[0] = '{5'b00011, 2'b01, 1'b0, 5'b10001};
      sv[1] = '{5'b00011, 2'b10, 1'b0, 5'b00110};
      sv[2] = '{5'b10000, 2'b10, 1'b0, 5'b00001};
      sv[3] = '{5'b00011, 2'b11, 1'b1, 5'b10001};
      sv[4] = '{5'b00011, 2'b11, 1'b0, 5'b00001};
      sv[5] = '{5'b10110, 2'b00, 1'b1, 5'b10110};
      sv[6] = '{5'b01101, 2'b01, 1'b0, 5'b10110};

      bv[0] = '{5'b00011, 2'b10, 1'b0, 4'd2,  1'b0, 5'b01100};
      bv[1] = '{5'b00011, 2'b11, 1'b1, 4'd3,  1'b0, 5'b11100};
      bv[2] = '{5'b00011, 2'b11, 1'b1, 4'd0,  1'b0, 5'b00011};
      bv[3] = '{5'b00011, 2'b01, 1'b0, 4'd5,  1'b1, 5'b00011};
      bv[4] = '{5'b00011, 2'b10, 1'b0, 4'd7,  1'b1, 5'b01100};
      bv[5] = '{5'b10110, 2'b00, 1'b0, 4'd4,  1'b0, 5'b10110};
      bv[6] = '{5'b00001, 2'b01, 1'b0, 4'd15, 1'b1, 5'b00001};

      clear        = 1'b0;
      enablePreset = 1'b0;
      preset       = 5'b0;
      mode         = 2'b00;
      serialIn     = 1'b0;
      enableShift  = 1'b0;
      start        = 1'b0;
      count        = 4'd0;

      // Reset state
      #2;
      chk("rst_out", out, 5'b00000);
      chk("rst_notout", notout, 5'b11111);
      chk("rst_serialout", serialOut, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clk);
      clear = 1'b1;
      tick();
      chk("post_rst_out", out, 5'b00000);
      chk("post_rst_busy", busy, 1'b0);

      // Single-step table
      for (int i = 0; i < 7; i++) begin
         load(sv[i].pre);
         mode        = sv[i].md;
         serialIn    = sv[i].si;
         enableShift = 1'b1;
         tick();
         enableShift = 1'b0;
         e = ~sv[i].exp;
         chk($sformatf("step%0d_out", i), out, sv[i].exp);
         chk($sformatf("step%0d_notout", i), notout, e);
         chk($sformatf("step%0d_serialout", i), serialOut, sv[i].exp[0]);
         chk($sformatf("step%0d_busy", i), busy, 1'b0);
      end

      // Held enableShift, rotate right, five edges
      load(5'b00011);
      mode        = 2'b01;
      enableShift = 1'b1;
      tick(); chk("rr_seq1", out, 5'b10001);
      tick(); chk("rr_seq2", out, 5'b11000);
      tick(); chk("rr_seq3", out, 5'b01100);
      tick(); chk("rr_seq4", out, 5'b00110);
      tick(); chk("rr_seq5", out, 5'b00011);
      enableShift = 1'b0;

      // Burst table
      for (int i = 0; i < 7; i++) begin
         load(bv[i].pre);
         mode     = bv[i].md;
         serialIn = bv[i].si;
         count    = bv[i].cnt;
         start    = 1'b1;
         tick();
         start = 1'b0;
         nbusy = 0;
         guard = 0;
         while (busy === 1'b1 && guard < 40) begin
            chk($sformatf("burst%0d_done_in_run", i), done, 1'b0);
            nbusy++;
            if (bv[i].disturb) begin
               mode        = 2'($urandom_range(0, 3));
               start       = 1'($urandom_range(0, 1));
               enableShift = 1'($urandom_range(0, 1));
               count       = 4'($urandom_range(0, 15));
            end
            tick();
            guard++;
         end
         start       = 1'b0;
         enableShift = 1'b0;
         chk($sformatf("burst%0d_timeout", i), (guard < 40), 1'b1);
         chk($sformatf("burst%0d_busy_cycles", i), nbusy, bv[i].cnt);
         chk($sformatf("burst%0d_done", i), done, 1'b1);
         chk($sformatf("burst%0d_out", i), out, bv[i].exp);
         chk($sformatf("burst%0d_serialout", i), serialOut, bv[i].exp[0]);
         if (bv[i].disturb) begin
            start        = 1'b1;
            enableShift  = 1'b1;
            enablePreset = 1'b1;
            preset       = 5'b11111;
         end
         tick();
         start        = 1'b0;
         enableShift  = 1'b0;
         enablePreset = 1'b0;
         chk($sformatf("burst%0d_done_clr", i), done, 1'b0);
         chk($sformatf("burst%0d_idle", i), busy, 1'b0);
         chk($sformatf("burst%0d_out_hold", i), out, bv[i].exp);
      end

      // Abort by enablePreset on the third RUN cycle
      load(5'b00011);
      mode  = 2'b01;
      count = 4'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("abort_run1_busy", busy, 1'b1);
      tick();
      tick();
      chk("abort_run3_out", out, 5'b11000);
      chk("abort_run3_busy", busy, 1'b1);
      preset       = 5'b10101;
      enablePreset = 1'b1;
      tick();
      enablePreset = 1'b0;
      chk("abort_out", out, 5'b10101);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("abort_no_done", done, 1'b0);
      end
      chk("abort_out_final", out, 5'b10101);

      // Asynchronous clear in the middle of a burst
      load(5'b00011);
      mode  = 2'b10;
      count = 4'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("aclr_pre_busy", busy, 1'b1);
      #2;
      clear = 1'b0;
      #1;
      chk("aclr_out", out, 5'b00000);
      chk("aclr_notout", notout, 5'b11111);
      chk("aclr_serialout", serialOut, 1'b0);
      chk("aclr_busy", busy, 1'b0);
      chk("aclr_done", done, 1'b0);
      tick();
      chk("aclr_held_out", out, 5'b00000);
      @(negedge clk);
      clear        = 1'b1;
      preset       = 5'b01010;
      enablePreset = 1'b1;
      tick();
      enablePreset = 1'b0;
      chk("aclr_first_edge_out", out, 5'b01010);
      chk("aclr_first_edge_done", done, 1'b0);
      tick();
      chk("aclr_no_done", done, 1'b0);
      chk("aclr_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
